// File: rtl/gate_sweep_checker_pkg.sv
// Shared encodings for the gate sweep checker.
// Holds the gate-function (op) encodings and the checker FSM state encoding.
package gate_sweep_checker_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'd0;
  localparam op_t OP_OR   = 2'd1;
  localparam op_t OP_XOR  = 2'd2;
  localparam op_t OP_NAND = 2'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Reference model for the gate under test.
// Ports:
//   op       - gate function (OP_AND, OP_OR, OP_XOR, OP_NAND)
//   A, B     - gate inputs
//   expected - value a correct gate of that function would produce
module gate_ref_model
  import gate_sweep_checker_pkg::*;
(
  input  logic [1:0] op,
  input  logic       A,
  input  logic       B,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = A & B;
      OP_OR:   expected = A | B;
      OP_XOR:  expected = A ^ B;
      OP_NAND: expected = ~(A & B);
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Truth-table sweep checker for a 2-input gate.
// On start, drives the four input vectors 00,01,10,11 onto A/B, holds each for
// SETTLE_CYCLES cycles, compares the gate output O against the reference model
// on the last cycle of each vector and reports the result.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - sweep request, sampled only while idle
//   op         - expected gate function, latched when start is accepted
//   A, B       - registered stimulus to the gate under test
//   O          - gate under test output (same clock domain)
//   busy       - sweep in progress
//   done       - one-cycle completion pulse
//   pass       - last sweep had no mismatches (held until next start)
//   fail_vec   - bit i set when vector i mismatched (held until next start)
//   err_count  - mismatch count of last sweep (held until next start)
module gate_sweep_checker
  import gate_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       A,
  output logic       B,
  input  logic       O,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] op_q;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       expected;
  logic       mismatch;

  gate_ref_model u_ref (
    .op       (op_q),
    .A        (A),
    .B        (B),
    .expected (expected)
  );

  assign mismatch = (O != expected);
  assign busy     = (state == SETTLE);

  // done and pass are registered on the edge leaving DONE, so the pulse
  // appears in the cycle after the DONE state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      idx       <= '0;
      cnt       <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= '0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            fail_vec  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            cnt       <= CNT_LOAD;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            if (mismatch) begin
              fail_vec[idx] <= 1'b1;
              err_count     <= err_count + 3'd1;
            end
            if (idx != 2'd3) begin
              idx    <= idx + 2'd1;
              {A, B} <= idx + 2'd1;
              cnt    <= CNT_LOAD;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (fail_vec == '0);
          A     <= 1'b0;
          B     <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (SETTLE_CYCLES 2, 1, 15), each
// with a configurable gate under test driving O. Expected sweep results are
// pushed to a scoreboard queue when start is driven and popped at done.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [3];
  logic [1:0] op        [3];
  logic       A         [3];
  logic       B         [3];
  logic       O         [3];
  logic       busy      [3];
  logic       done      [3];
  logic       pass      [3];
  logic [3:0] fail_vec  [3];
  logic [2:0] err_count [3];
  int         gut       [3];
  int unsigned settle   [3];

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [3:0]  fv;
    logic [2:0]  ec;
    logic        ps;
    int unsigned done_cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Truth tables indexed by {a,b}: AND, OR, XOR, NAND.
  function automatic logic tbl(input int g, input logic a, input logic b);
    logic [3:0] t;
    case (g)
      0:       t = 4'b1000;
      1:       t = 4'b1110;
      2:       t = 4'b0110;
      default: t = 4'b0111;
    endcase
    return t[{a, b}];
  endfunction

  assign O[0] = tbl(gut[0], A[0], B[0]);
  assign O[1] = tbl(gut[1], A[1], B[1]);
  assign O[2] = tbl(gut[2], A[2], B[2]);

  gate_sweep_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .op(op[0]), .A(A[0]), .B(B[0]),
    .O(O[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_vec(fail_vec[0]), .err_count(err_count[0])
  );

  gate_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .op(op[1]), .A(A[1]), .B(B[1]),
    .O(O[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_vec(fail_vec[1]), .err_count(err_count[1])
  );

  gate_sweep_checker #(.SETTLE_CYCLES(15)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .op(op[2]), .A(A[2]), .B(B[2]),
    .O(O[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .fail_vec(fail_vec[2]), .err_count(err_count[2])
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic run_sweep(input int inst, input logic [1:0] o, input int g, input bit disturb);
    exp_t        e;
    int unsigned acc;
    int unsigned s;
    int unsigned good;
    logic [1:0]  v;
    s = settle[inst];
    gut[inst] = g;
    op[inst] = o;
    start[inst] = 1'b1;
    acc = cyc + 1;
    e.fv = '0;
    e.ec = '0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (tbl(int'(o), v[1], v[0]) != tbl(g, v[1], v[0])) begin
        e.fv[i] = 1'b1;
        e.ec = e.ec + 3'd1;
      end
    end
    e.ps = (e.ec == 0);
    e.done_cyc = acc + 4 * s + 1;
    sb.push_back(e);

    @(negedge clk);
    start[inst] = 1'b0;
    good = 0;
    for (int unsigned k = 0; k < 4 * s; k++) begin
      if (k > 0) @(negedge clk);
      if (disturb && k == s) begin
        start[inst] = 1'b1;
        op[inst] = o ^ 2'b10;
      end
      if (disturb && k == s + 1) start[inst] = 1'b0;
      if ({A[inst], B[inst]} == 2'(k / s) && busy[inst] && !done[inst]) good++;
    end
    check($sformatf("hold_busy%0d", inst), good, 4 * s);

    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done[inst]) break;
    end
    e = sb.pop_front();
    check($sformatf("done_edge%0d", inst), cyc, e.done_cyc);
    check($sformatf("fail_vec%0d", inst), int'(fail_vec[inst]), int'(e.fv));
    check($sformatf("err_count%0d", inst), int'(err_count[inst]), int'(e.ec));
    check($sformatf("pass%0d", inst), int'(pass[inst]), int'(e.ps));
    check($sformatf("ab_idle%0d", inst), int'({A[inst], B[inst]}), 0);
    @(negedge clk);
    check($sformatf("done_pulse%0d", inst), int'({done[inst], busy[inst]}), 0);
    check($sformatf("pass_held%0d", inst), int'(pass[inst]), int'(e.ps));
    op[inst] = o;
  endtask

  initial begin
    int unsigned seen;
    settle[0] = 2;
    settle[1] = 1;
    settle[2] = 15;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      op[i] = 2'd0;
      gut[i] = 1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", int'({A[0], B[0], busy[0], done[0], pass[0]}), 0);
    check("rst_fail_vec", int'(fail_vec[0]), 0);
    check("rst_err_count", int'(err_count[0]), 0);

    // First start lands on the first edge after reset release.
    rst = 1'b0;
    run_sweep(0, 2'd1, 1, 1'b0);  // OR vs OR
    run_sweep(0, 2'd0, 1, 1'b0);  // AND vs OR
    run_sweep(0, 2'd3, 1, 1'b0);  // NAND vs OR
    run_sweep(0, 2'd2, 1, 1'b0);  // XOR vs OR
    run_sweep(0, 2'd0, 1, 1'b1);  // AND vs OR, start/op disturbed mid-sweep

    // Reset during vector 2.
    start[0] = 1'b1;
    op[0] = 2'd1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_vec2", int'({A[0], B[0], busy[0]}), 3'b101);
    #1 rst = 1'b1;
    #1 check("rst_async", int'({A[0], B[0], busy[0], done[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen++;
    end
    check("no_done_after_abort", seen, 0);
    run_sweep(0, 2'd1, 1, 1'b0);

    run_sweep(1, 2'd1, 1, 1'b0);  // S=1, OR vs OR
    run_sweep(1, 2'd2, 1, 1'b0);  // S=1, XOR vs OR
    run_sweep(2, 2'd3, 3, 1'b0);  // S=15, NAND vs NAND
    run_sweep(2, 2'd0, 1, 1'b0);  // S=15, AND vs OR

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
